mfun_step: RTL and testbench



---
 rtl/mfun_step.sv | 113 +++++++++++
 tb/tb_mfun_step.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mfun_step.sv
// Bit-serial LFSR step engine: loads phase and taps, accumulates feedback parity one bit per cycle,
// then presents the shifted phase, the feedback bit and a one-cycle strobe. Optional macro: MFUN_ZERO_GUARD_EN.
module mfun_step #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fase,
    input  logic [WIDTH-1:0] type_f,
    output logic [WIDTH-1:0] fase_new,
    output logic             sum,
    output logic             control
);

    // state  | meaning
    // LOAD   | capture fase/type_f into shadow registers, clear accumulator and index
    // ACC    | fold one tapped phase bit per cycle into the parity accumulator
    // DONE   | publish sum and the shifted phase
    // STROBE | raise control for the following cycle

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ACC    = 2'd1,
        DONE   = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] fase_new_q, fase_new_d;
    logic             sum_q, sum_d;
    logic             control_q, control_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            f_q        <= '0;
            t_q        <= '0;
            acc_q      <= 1'b0;
            idx_q      <= '0;
            fase_new_q <= '0;
            sum_q      <= 1'b0;
            control_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_q        <= f_d;
            t_q        <= t_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            fase_new_q <= fase_new_d;
            sum_q      <= sum_d;
            control_q  <= control_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        t_d        = t_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        fase_new_d = fase_new_q;
        sum_d      = sum_q;
        control_d  = 1'b0;

        case (state_q)
            LOAD: begin
`ifdef MFUN_ZERO_GUARD_EN
                // Seed the LSB so an all-zero phase cannot lock the sequence.
                f_d = (fase == '0) ? WIDTH'(1) : fase;
`else
                f_d = fase;
`endif
                t_d     = type_f;
                acc_d   = 1'b0;
                idx_d   = '0;
                state_d = ACC;
            end
            ACC: begin
                acc_d = acc_q ^ (f_q[idx_q] & t_q[idx_q]);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                sum_d      = acc_q;
                fase_new_d = {f_q[WIDTH-2:0], acc_q};
                state_d    = STROBE;
            end
            STROBE: begin
                // Registered, so control is visible the cycle after STROBE, once outputs have settled.
                control_d = 1'b1;
                state_d   = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign fase_new = fase_new_q;
    assign sum      = sum_q;
    assign control  = control_q;

endmodule

// File: tb/tb_mfun_step.sv
// Self-checking bench for mfun_step: expected steps are queued when the phase for the next LOAD
// is driven, and popped on every control strobe.
module tb_mfun_step;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] fase = '0;
    logic [W-1:0] type_f = '0;
    logic [W-1:0] fase_new;
    logic         sum;
    logic         control;

    int total = 0;
    int bad = 0;
    logic [W:0] sb_q[$];

    mfun_step #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fase     (fase),
        .type_f   (type_f),
        .fase_new (fase_new),
        .sum      (sum),
        .control  (control)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference step: {sum, fase_new}
    function automatic logic [W:0] ref_step(input logic [W-1:0] f, input logic [W-1:0] t);
        logic [W-1:0] ff;
        logic         p;
        ff = f;
`ifdef MFUN_ZERO_GUARD_EN
        if (ff == '0) ff = 1;
`endif
        p = ^(ff & t);
        return {p, ff[W-2:0], p};
    endfunction

    task automatic sb_push();
        sb_q.push_back(ref_step(fase, type_f));
    endtask

    task automatic sb_pop_check();
        logic [W:0] e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_sum", 32'(sum), 32'(e[W]));
            chk("sb_fase_new", 32'(fase_new), 32'(e[W-1:0]));
        end
    endtask

    // Waits for the next strobe; n = posedges elapsed since the call.
    task automatic step_wait(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (control) begin
                sb_pop_check();
                return;
            end
        end
        chk("strobe_timeout", 1, 0);
    endtask

    task automatic do_reset(input logic [W-1:0] f, input logic [W-1:0] t);
        @(negedge clk);
        rst_n = 1'b0;
        fase = f;
        type_f = t;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        sb_push();
    endtask

    initial begin
        int n;
        logic [W-1:0] exp_ph[6];
        logic         exp_sm[6];
        logic         mls_sm[5];

        // Reset state
        @(negedge clk);
        rst_n = 1'b0;
        fase = 4'b0101;
        type_f = 4'b0101;
        repeat (2) @(negedge clk);
        chk("rst_control", 32'(control), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_fase_new", 32'(fase_new), 0);

        // First-step latency, stability, period and width
        rst_n = 1'b1;
        sb_q.delete();
        sb_push();
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("first_ctrl_e%0d", e), 32'(control), (e == 7) ? 1 : 0);
            if (e == 6) begin
                chk("e6_sum", 32'(sum), 0);
                chk("e6_fase_new", 32'(fase_new), 32'(4'b1010));
            end
            if (e == 7) sb_pop_check();
        end
        sb_push();
        @(posedge clk);
        @(negedge clk);
        chk("ctrl_width", 32'(control), 0);
        step_wait(n);
        chk("period", 32'(n + 1), 7);

        // Closed loop, taps 0101
        exp_sm = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ph = '{4'b1010, 4'b0100, 4'b1001, 4'b0011, 4'b0111, 4'b1110};
        do_reset(4'b0101, 4'b0101);
        for (int k = 0; k < 6; k++) begin
            step_wait(n);
            chk($sformatf("loop_sum%0d", k), 32'(sum), 32'(exp_sm[k]));
            chk($sformatf("loop_ph%0d", k), 32'(fase_new), 32'(exp_ph[k]));
            fase = fase_new;
            sb_push();
        end

        // Maximal-length sequence, taps 1001
        mls_sm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset(4'b0001, 4'b1001);
        for (int k = 0; k < 15; k++) begin
            step_wait(n);
            if (k < 5) chk($sformatf("mls_sum%0d", k), 32'(sum), 32'(mls_sm[k]));
            if (k < 14) chk($sformatf("mls_early%0d", k), 32'(fase_new == 4'b0001), 0);
            else chk("mls_return", 32'(fase_new), 32'(4'b0001));
            fase = fase_new;
            sb_push();
        end

        // Mid-step input change
        do_reset(4'b0101, 4'b0101);
        repeat (3) @(posedge clk);
        @(negedge clk);
        fase = 4'b1111;
        step_wait(n);
        chk("midchg_ph1", 32'(fase_new), 32'(4'b1010));
        sb_push();
        step_wait(n);
        chk("midchg_sum2", 32'(sum), 0);
        chk("midchg_ph2", 32'(fase_new), 32'(4'b1110));

        // Reset pulse during ACC
        do_reset(4'b0101, 4'b0101);
        step_wait(n);
        chk("pre_abort_ph", 32'(fase_new), 32'(4'b1010));
        sb_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_control", 32'(control), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_fase_new", 32'(fase_new), 0);
        rst_n = 1'b1;
        sb_push();
        step_wait(n);
        chk("abort_restart_edges", 32'(n), 7);

        // All-zero phase
        do_reset(4'b0000, 4'b1001);
        step_wait(n);
`ifdef MFUN_ZERO_GUARD_EN
        chk("zero_sum", 32'(sum), 1);
        chk("zero_ph", 32'(fase_new), 32'(4'b0011));
`else
        chk("zero_sum", 32'(sum), 0);
        chk("zero_ph", 32'(fase_new), 32'(4'b0000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
